// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 6;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-entry write-port priority resolution: for every entry, the highest-index
// enabled port addressing it supplies the write enable and data.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_WR = 2,
  parameter int DEPTH  = rf_depth(RF_ADDR_W)
) (
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DEPTH-1:0]         ent_we,
  output logic [DEPTH*DATA_W-1:0]  ent_wdata
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic              we;
      logic [DATA_W-1:0] wd;

      // Ascending scan: a later (higher-index) port overrides earlier hits.
      always_comb begin
        we = 1'b0;
        wd = '0;
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(gi))) begin
            we = 1'b1;
            wd = wr_data[i*DATA_W +: DATA_W];
          end
        end
      end

      assign ent_we[gi]                   = we;
      assign ent_wdata[gi*DATA_W +: DATA_W] = wd;
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and a post-reset clear sweep.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter bit ZERO_REG0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr
);

  localparam int                DEPTH    = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ready_q, ready_d;

  // No declaration initialiser on the array: every read is forced to 0 until
  // the sweep has written every entry, so unset contents never reach an output.
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic              run;
  logic              clear_en;
  logic              alloc_ok;
  logic [NUM_WR-1:0] wr_en_m;
  logic [DEPTH-1:0]        ent_we;
  logic [DEPTH*DATA_W-1:0] ent_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
      end
    endcase
  end

  assign ready    = ready_q;
  assign run      = (state_q == RUN) && !rst;
  assign clear_en = (state_q == CLEAR) && !rst;
  assign alloc_ok = run && alloc_en && !(ZERO_REG0 && (alloc_addr == '0));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wmask
      assign wr_en_m[gi] = run && wr_en[gi] &&
                           !(ZERO_REG0 && (wr_addr[gi*ADDR_W +: ADDR_W] == '0));
    end
  endgenerate

  regfile_wr_arb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR),
    .DEPTH  (DEPTH)
  ) u_wr_arb (
    .wr_en     (wr_en_m),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ent_we    (ent_we),
    .ent_wdata (ent_wdata)
  );

  always_ff @(posedge clk) begin
    if (clear_en) begin
      regs_q[clr_cnt_q] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_we[e]) begin
          regs_q[e] <= ent_wdata[e*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Alloc takes precedence over a same-cycle write: the producer is still pending.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign busy_d[gi] = (alloc_ok && (alloc_addr == ADDR_W'(gi))) ? 1'b1 :
                          ent_we[gi]                                ? 1'b0 :
                                                                      busy_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clear_en) begin
      busy_q[clr_cnt_q] <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              b;

      assign a = rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        d = regs_q[a];
        b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
        if (ent_we[a]) begin
          d = ent_wdata[a*DATA_W +: DATA_W];
          b = alloc_ok && (alloc_addr == a);
        end
`endif
        if (!run || (ZERO_REG0 && (a == '0))) begin
          d = '0;
          b = 1'b0;
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = d;
      assign rd_busy[gi]                  = b;
    end
  endgenerate

endmodule
